l1_hit_buffer_ctrl: RTL and testbench

Address and readout controller for the per-pixel L1 hit buffer SRAM. It runs the free-running circular write pointer and turns each L1 accept into a read address of `wrAddr - latency`. It queues pending reads, drives the SRAM read port, and delivers each returned hit bit with its buffer address to the downstream readout through a valid/ready handshake. It sits directly upstream of the hit-buffer SRAM wrapper, which writes every cycle and returns read data one cycle after `rden`.

---
 rtl/l1_hit_buffer_ctrl_pkg.sv | 17 +
 rtl/l1_trig_addr_fifo.sv | 60 ++++++
 rtl/l1_hit_buffer_ctrl.sv | 117 +++++++++++
 tb/tb_l1_hit_buffer_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/l1_hit_buffer_ctrl_pkg.sv
// Shared defaults and types for the L1 hit-buffer address/readout controller.
package l1_hit_buffer_ctrl_pkg;

  localparam int ADDRWIDTH_DEF = 9;
  localparam int FIFODEPTH_DEF = 4;
  localparam int DROPCNT_W     = 8;

  typedef struct packed {
    logic                     hit;
    logic [ADDRWIDTH_DEF-1:0] addr;
  } out_entry_t;

  function automatic logic [DROPCNT_W-1:0] sat_inc(input logic [DROPCNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/l1_trig_addr_fifo.sv
// Pending-trigger address FIFO; accepts a push while full only if a pop lands in the same cycle.
import l1_hit_buffer_ctrl_pkg::*;

module l1_trig_addr_fifo #(
  parameter int W     = ADDRWIDTH_DEF,
  parameter int DEPTH = FIFODEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PW:0]             count_q, count_d;
  logic                    wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so the read address presents 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/l1_hit_buffer_ctrl.sv
// Circular write pointer, L1 trigger address queue, SRAM read issue and 2-entry skid readout.
import l1_hit_buffer_ctrl_pkg::*;

module l1_hit_buffer_ctrl #(
  parameter int ADDRWIDTH = ADDRWIDTH_DEF,
  parameter int FIFODEPTH = FIFODEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRWIDTH-1:0] latency,
  input  logic                 l1a,
  output logic [ADDRWIDTH-1:0] wrAddr,
  output logic [ADDRWIDTH-1:0] rdAddr,
  output logic                 rden,
  input  logic                 outHit,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_hit,
  output logic [ADDRWIDTH-1:0] dout_addr,
  output logic                 overflow,
  output logic [DROPCNT_W-1:0] dropCount
);

  typedef struct packed {
    logic                 hit;
    logic [ADDRWIDTH-1:0] addr;
  } entry_t;

  logic [ADDRWIDTH-1:0] wr_addr_q;
  logic [ADDRWIDTH-1:0] push_addr;
  logic [ADDRWIDTH-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;
  logic [$clog2(FIFODEPTH):0] fifo_count;

  logic                 infl_q;
  logic [ADDRWIDTH-1:0] infl_addr_q;
  entry_t [1:0]         skid_q, skid_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;
  logic                 overflow_q;
  logic [DROPCNT_W-1:0] drop_cnt_q;

  logic       out_fire, issue, drop;
  logic [1:0] occ, occ_net;

  assign push_addr = wr_addr_q - latency;
  assign out_fire  = (skid_cnt_q != 2'd0) && dout_ready;

  // Room is counted against what the skid will hold once this cycle's pop and the in-flight read settle.
  assign occ     = skid_cnt_q + {1'b0, infl_q};
  assign occ_net = occ - {1'b0, out_fire};
  assign issue   = !fifo_empty && (occ_net < 2'd2);
  assign drop    = l1a && fifo_full && !issue;

  l1_trig_addr_fifo #(
    .W     (ADDRWIDTH),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (l1a),
    .pop_i   (issue),
    .din_i   (push_addr),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt_q;
    if (out_fire) begin
      skid_d[0]  = skid_q[1];
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
    if (infl_q) begin
      if (skid_cnt_d == 2'd0) skid_d[0] = '{hit: outHit, addr: infl_addr_q};
      else                    skid_d[1] = '{hit: outHit, addr: infl_addr_q};
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_q   <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      skid_q      <= '0;
      skid_cnt_q  <= 2'd0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_addr_q   <= wr_addr_q + 1'b1;
      infl_q      <= issue;
      if (issue) infl_addr_q <= fifo_head;
      skid_q      <= skid_d;
      skid_cnt_q  <= skid_cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  assign wrAddr     = wr_addr_q;
  assign rdAddr     = fifo_head;
  assign rden       = issue;
  assign dout_valid = (skid_cnt_q != 2'd0);
  assign dout_hit   = skid_q[0].hit;
  assign dout_addr  = skid_q[0].addr;
  assign overflow   = overflow_q;
  assign dropCount  = drop_cnt_q;

  a_fifo_count: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= ($clog2(FIFODEPTH)+1)'(FIFODEPTH));

endmodule

// File: tb/tb_l1_hit_buffer_ctrl.sv
// Bench for l1_hit_buffer_ctrl with a 1-cycle-latency SRAM model and an in-order scoreboard.
module tb_l1_hit_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] latency = '0;
  logic       l1a = 1'b0;
  logic [8:0] wrAddr, rdAddr, dout_addr;
  logic       rden, dout_valid, dout_hit, overflow;
  logic       outHit = 1'b0;
  logic       dout_ready = 1'b1;
  logic [7:0] dropCount;

  l1_hit_buffer_ctrl #(.ADDRWIDTH(9), .FIFODEPTH(4)) dut (
    .clk(clk), .reset(reset), .latency(latency), .l1a(l1a),
    .wrAddr(wrAddr), .rdAddr(rdAddr), .rden(rden), .outHit(outHit),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_hit(dout_hit),
    .dout_addr(dout_addr), .overflow(overflow), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  // SRAM content is a fixed function of address, so any read returns that bit.
  function automatic logic hbit(input logic [8:0] a);
    return a[0] ^ a[3] ^ a[5];
  endfunction

  always @(posedge clk) if (rden) outHit <= hbit(rdAddr);

  logic [8:0] tb_wr = '0;
  always @(posedge clk) tb_wr <= reset ? 9'd0 : tb_wr + 9'd1;

  typedef struct packed { logic hit; logic [8:0] addr; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0, delivered = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_exp(input logic [8:0] a);
    q.push_back('{hit: hbit(a), addr: a});
  endtask

  logic       stall_q = 1'b0;
  logic       st_hit = 1'b0;
  logic [8:0] st_addr = '0;
  exp_t       e;

  always @(negedge clk) begin
    if (reset) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        checks++;
        if (!dout_valid || dout_hit !== st_hit || dout_addr !== st_addr) begin
          errors++;
          $display("FAIL stable: got v=%0d hit=%0d addr=%0d expected v=1 hit=%0d addr=%0d",
                   dout_valid, dout_hit, dout_addr, st_hit, st_addr);
        end
      end
      if (dout_valid && dout_ready) begin
        delivered++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got addr=%0d expected no output", dout_addr);
        end else begin
          e = q.pop_front();
          chk("sb_addr", int'(dout_addr), int'(e.addr));
          chk("sb_hit", int'(dout_hit), int'(e.hit));
        end
      end
      stall_q = dout_valid && !dout_ready;
      st_hit  = dout_hit;
      st_addr = dout_addr;
    end
  end

  typedef struct { int lat; int start; int exp_addr; int exp_hit; } vec_t;
  vec_t tv[5];

  task automatic drain(input string name);
    for (int k = 0; k < 200 && q.size() != 0; k++) tick();
    chk(name, q.size(), 0);
  endtask

  initial begin
    int d0;
    tv[0] = '{lat: 10,  start: 100, exp_addr: 90,  exp_hit: 1};
    tv[1] = '{lat: 10,  start: 5,   exp_addr: 507, exp_hit: 1};
    tv[2] = '{lat: 0,   start: 300, exp_addr: 300, exp_hit: 0};
    tv[3] = '{lat: 504, start: 10,  exp_addr: 18,  exp_hit: 0};
    tv[4] = '{lat: 1,   start: 0,   exp_addr: 511, exp_hit: 1};

    tick(); tick(); tick();
    chk("rst_wrAddr", wrAddr, 0);
    chk("rst_rdAddr", rdAddr, 0);
    chk("rst_rden", rden, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_hit", dout_hit, 0);
    chk("rst_addr", dout_addr, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropCount", dropCount, 0);
    reset = 1'b0;
    tick();

    // Single-trigger latency/wrap vectors
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 600 && tb_wr != 9'(tv[i].start); k++) tick();
      chk("vec_wrAddr", wrAddr, tv[i].start);
      latency = 9'(tv[i].lat);
      l1a = 1'b1;
      push_exp(9'(tv[i].exp_addr));
      tick();
      l1a = 1'b0;
      chk("vec_rden", rden, 1);
      chk("vec_rdAddr", rdAddr, tv[i].exp_addr);
      tick();
      chk("vec_valid_t2", dout_valid, 0);
      tick();
      chk("vec_valid_t3", dout_valid, 1);
      chk("vec_dout_addr", dout_addr, tv[i].exp_addr);
      chk("vec_dout_hit", dout_hit, tv[i].exp_hit);
      tick(); tick();
    end

    // Burst of 6 at wrAddr 200..205
    latency = 9'd10;
    for (int k = 0; k < 600 && tb_wr != 9'd200; k++) tick();
    for (int i = 0; i < 11; i++) begin
      if (i < 6) begin l1a = 1'b1; push_exp(9'(190 + i)); end
      else l1a = 1'b0;
      if (i >= 3 && i <= 8) chk("burst_valid", dout_valid, 1);
      if (i >= 9) chk("burst_idle", dout_valid, 0);
      tick();
    end
    chk("burst_overflow", overflow, 0);
    drain("burst_drain");

    // Overflow: 8 triggers into a stalled pipe, last two dropped
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      l1a = 1'b1;
      if (i < 6) push_exp(tb_wr - 9'd10);
      tick();
    end
    l1a = 1'b0;
    tick(); tick(); tick();
    chk("ovf_dropCount", dropCount, 2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_valid", dout_valid, 1);
    d0 = delivered;
    dout_ready = 1'b1;
    drain("ovf_drain");
    for (int k = 0; k < 5; k++) tick();
    chk("ovf_delivered", delivered - d0, 6);

    // Backpressure toggling during a 5-trigger burst
    d0 = delivered;
    for (int i = 0; i < 30; i++) begin
      l1a = (i < 5);
      if (i < 5) push_exp(tb_wr - 9'd10);
      dout_ready = (i % 2 == 0);
      tick();
    end
    l1a = 1'b0;
    dout_ready = 1'b1;
    drain("bp_drain");
    chk("bp_delivered", delivered - d0, 5);
    chk("bp_dropCount", dropCount, 2);

    // Reset with entries queued and output valid
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      l1a = 1'b1;
      push_exp(tb_wr - 9'd10);
      tick();
    end
    l1a = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_valid", dout_valid, 1);
    reset = 1'b1;
    l1a = 1'b1;
    tick();
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_rden", rden, 0);
    chk("mrst_wrAddr", wrAddr, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_dropCount", dropCount, 0);
    reset = 1'b0;
    l1a = 1'b0;
    q.delete();
    d0 = delivered;
    dout_ready = 1'b1;
    tick();
    chk("post_rden", rden, 0);
    chk("post_wrAddr", wrAddr, 1);
    for (int k = 0; k < 20; k++) tick();
    chk("post_no_stale", delivered - d0, 0);

    latency = 9'd3;
    l1a = 1'b1;
    push_exp(tb_wr - 9'd3);
    tick();
    l1a = 1'b0;
    drain("post_drain");
    tick(); tick();
    chk("post_delivered", delivered - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
